mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 single-port synchronous memory.
- The memory has 1-cycle read latency; when ce is high, a read takes priority over a write.
- Requesters are the APB slave side (port 0) and the I2C engine side (port 1).
- Grants the memory to one requester at a time, round-robin. Drives the memory ce/rden/wren/addr/wr_data. Captures read data and returns a one-cycle ack per transfer.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request; held high until ack0.
- wr0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, wr1, addr1, wdata1, ack1  same as above, for requester 1.
- rdata  out  DATA_W  read data; valid while ack0/ack1 is high for a read.
- gnt_id  out  1  index of the requester owning the current or last transfer.
- busy  out  1  high in any state other than IDLE.
- mem_ce  out  1  memory chip enable.
- mem_rden  out  1  memory read enable.
- mem_wren  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data; valid the cycle after a read issue.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, rdata=0, gnt_id=0, last_grant=1 (so port 0 wins the first tie), latched op registers=0.
- States: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the port != last_grant.
  - On granting edge: latch winner's wr/addr/wdata, set gnt_id and last_grant, go ISSUE.
- ISSUE (1 cycle):
  - mem_ce=1, mem_addr=latched addr.
  - Write: mem_wren=1, mem_rden=0, mem_wr_data=latched wdata; next ACK.
  - Read: mem_rden=1, mem_wren=0; next CAPTURE.
- CAPTURE (reads only, 1 cycle): mem_ce=0; at end of cycle rdata <= mem_rd_data; next ACK.
- ACK (1 cycle): ack[gnt_id]=1, other ack=0; next IDLE.
- Outside ISSUE, mem_ce/mem_rden/mem_wren are 0.
- Timing:
  - mem_* outputs are decoded from the state register and latched op registers only. No combinational path from req/addr/wdata inputs to memory ports.
  - Latency from the IDLE edge that samples req: write ack in cycle 2, read ack in cycle 3.
  - The earliest re-grant is the cycle after ACK, so throughput is 1 write per 3 cycles and 1 read per 4 cycles.
- rdata is updated only by CAPTURE. It holds its value across writes and idle, and is shared by both ports.
- A requester may drop req only after sampling its ack. If req is still high in the IDLE after ACK, it is a new request.
- Inputs changing after grant are ignored; the access completes with the latched values. A req dropped early still produces the ack.
- Both req held continuously: grants alternate 0,1,0,1.
- A single port requesting continuously is granted back-to-back. last_grant does not block an uncontested request.
- Reset mid-operation:
  - Immediate return to IDLE; mem_ce drops asynchronously.
  - A write in ISSUE whose edge has not yet occurred is not performed.
  - No ack is issued for the aborted transfer. last_grant returns to 1.
- Address and data pass through unmodified (no arithmetic). Addresses 0x00 and 0xFF need no special handling.

Test Plan:
- Reset: hold rst_n=0 with req0=req1=1 -> all outputs 0, busy=0, no mem_ce. Release -> port 0 granted first (gnt_id=0).
- Write then read, port 0: write addr 0x3C data 0xA5 -> ack0 exactly 2 cycles after grant sample, with mem_wren/mem_ce high 1 cycle, addr 0x3C. Then read 0x3C -> ack0 3 cycles after grant sample, rdata=0xA5.
- Contention: req0 and req1 both held, four reads of 0x10 (port 0) and 0x20 (port 1) preloaded 0x11/0x22 -> grant order 0,1,0,1; rdata 0x11,0x22,0x11,0x22 with the matching ack.
- Single requester: req1 only, back-to-back writes to 0xFF then 0x00 -> both complete, gnt_id=1 throughout, no idle grant to port 0.
- Input change after grant: port 1 write 0x40 data 0x5A, then change addr1 to 0x41 during ISSUE -> memory written at 0x40 only; 0x41 unchanged.
- Reset mid-op: assert rst_n low during ISSUE of a write to 0x80 (old 0x00, new 0xFF) -> mem[0x80] stays 0x00, no ack, state IDLE, next tie granted to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-port arbiter and sequencer for a 256x8
//               single-port synchronous memory with 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt_id,
    output logic              busy,
    output logic              mem_ce,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_ACK     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              w_pick1;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign w_pick1 = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            c_IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = w_pick1;
                    last_d  = w_pick1;
                    wr_d    = w_pick1 ? wr1    : wr0;
                    addr_d  = w_pick1 ? addr1  : addr0;
                    wdata_d = w_pick1 ? wdata1 : wdata0;
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE:   state_d = wr_q ? c_ACK : c_CAPTURE;
            c_CAPTURE: begin
                rdata_d = mem_rd_data;
                state_d = c_ACK;
            end
            c_ACK:     state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Memory controls come only from registered state, so reset kills ce at once.
    assign mem_ce      = (state_q == c_ISSUE);
    assign mem_wren    = mem_ce & wr_q;
    assign mem_rden    = mem_ce & ~wr_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;

    assign ack0   = (state_q == c_ACK) & ~gnt_q;
    assign ack1   = (state_q == c_ACK) & gnt_q;
    assign busy   = (state_q != c_IDLE);
    assign rdata  = rdata_q;
    assign gnt_id = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, wr0, req1, wr1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, gnt_id, busy, mem_ce, mem_rden, mem_wren;
    logic [7:0] rdata, mem_addr, mem_wr_data, mem_rd_data;

    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         p;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;
    vec_t tbl [7];

    int         exp_port [4] = '{0, 1, 0, 1};
    logic [7:0] exp_dat  [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

    // random-phase reference state
    int         m_idle_from, m_issue_cyc, m_ack_cyc;
    bit         m_port, m_last, m_wr, e_ack, win;
    logic [7:0] m_addr, m_wdata, m_rd_exp, m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
        .mem_ce(mem_ce), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Single-port memory: read wins over write when both are enabled.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_ce && mem_rden) mem_rd_data <= mem[mem_addr];
        else if (mem_ce && mem_wren) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input bit p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (p) begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic rnd_op(input bit p, input bit r);
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                        : 8'h20 + 8'($urandom_range(0, 7));
        set_port(p, r, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    task automatic do_xfer(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
        @(negedge clk);
        set_port(p, 1'b1, w, a, d);
        lat = -1;
        rd  = 8'hxx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("issue_ce", mem_ce, 1);
                chk("issue_dir", {mem_wren, mem_rden}, {w, !w});
                chk("issue_addr", mem_addr, a);
                if (w) chk("issue_wdata", mem_wr_data, d);
            end
            if (p ? ack1 : ack0) begin
                lat = k;
                rd  = rdata;
                chk("ack_other", p ? ack0 : ack1, 0);
                break;
            end
        end
        set_port(p, 1'b0, w, a, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, n, c0, c1, first, second;
        logic [7:0] rd;
        bit         got;

        tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 2};
        tbl[1] = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 3};
        tbl[2] = '{1'b0, 1'b1, 8'h10, 8'h11, 8'hA5, 2};
        tbl[3] = '{1'b1, 1'b1, 8'h20, 8'h22, 8'hA5, 2};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h77, 8'hA5, 2};
        tbl[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h77, 3};
        tbl[6] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 3};

        // ---- reset with both requests pending ----
        rst_n = 1'b0;
        set_port(0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            pl_en = 1'b1; pl_addr = i[7:0]; pl_data = 8'h00;
            @(negedge clk);
        end
        pl_en = 1'b0;
        set_port(0, 1, 0, 8'h05, 8'h00);
        set_port(1, 1, 0, 8'h06, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {ack0, ack1, gnt_id, busy, mem_ce, mem_rden, mem_wren,
                             rdata, mem_addr, mem_wr_data}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt", gnt_id, 0);
        chk("rst_first_addr", mem_addr, 8'h05);
        chk("rst_first_busy", busy, 1);
        rst_n = 1'b0;
        set_port(0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven single transfers ----
        for (int i = 0; i < 7; i++) begin
            do_xfer(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, lat, rd);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_gnt", i), gnt_id, tbl[i].p);
        end

        // ---- contention: both ports hold reads ----
        @(negedge clk);
        set_port(0, 1, 0, 8'h10, 8'h00);
        set_port(1, 1, 0, 8'h20, 8'h00);
        n = 0; c0 = 0; c1 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk("cont_both_ack", ack0 && ack1, 0);
                if (n < 4) begin
                    chk($sformatf("cont%0d_port", n), ack1, exp_port[n]);
                    chk($sformatf("cont%0d_rdata", n), rdata, exp_dat[n]);
                end
                n++;
                if (ack0) begin c0++; if (c0 == 2) req0 = 1'b0; end
                if (ack1) begin c1++; if (c1 == 2) req1 = 1'b0; end
            end
            if (n == 4) break;
        end
        chk("cont_count", n, 4);
        req0 = 1'b0; req1 = 1'b0;

        // ---- single requester, back-to-back writes ----
        @(negedge clk);
        set_port(1, 1, 1, 8'hFF, 8'h3E);
        first = -1; second = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("single_gnt", gnt_id, 1);
            chk("single_ack0", ack0, 0);
            if (ack1) begin
                if (first < 0) begin
                    first = k;
                    set_port(1, 1, 1, 8'h00, 8'hC3);
                end else begin
                    second = k;
                    req1 = 1'b0;
                    break;
                end
            end
        end
        req1 = 1'b0;
        chk("single_first", first, 2);
        chk("single_second", second, 5);
        do_xfer(0, 0, 8'hFF, 8'h00, lat, rd);
        chk("single_rd_ff", rd, 8'h3E);
        do_xfer(0, 0, 8'h00, 8'h00, lat, rd);
        chk("single_rd_00", rd, 8'hC3);

        // ---- inputs change (and req drops) after grant ----
        @(negedge clk);
        set_port(1, 1, 1, 8'h40, 8'h5A);
        @(negedge clk);
        chk("ic_addr", mem_addr, 8'h40);
        set_port(1, 0, 1, 8'h41, 8'h99);
        got = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ack1) begin got = 1'b1; break; end
        end
        chk("ic_ack", got, 1);
        chk("ic_mem40", mem[8'h40], 8'h5A);
        chk("ic_mem41", mem[8'h41], 8'h00);

        // ---- reset during ISSUE of a write ----
        @(negedge clk);
        set_port(0, 1, 1, 8'h80, 8'hFF);
        @(negedge clk);
        chk("mid_issue", {mem_ce, mem_wren, mem_addr}, {2'b11, 8'h80});
        #1 rst_n = 1'b0;
        #1;
        chk("mid_ce_async", mem_ce, 0);
        chk("mid_busy", busy, 0);
        req0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_noack", {ack0, ack1}, 0);
        end
        chk("mid_mem80", mem[8'h80], 8'h00);
        set_port(0, 1, 0, 8'h07, 8'h00);
        set_port(1, 1, 0, 8'h08, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_tie_gnt", gnt_id, 0);
        chk("mid_tie_addr", mem_addr, 8'h07);
        rst_n = 1'b0;
        set_port(0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- randomized traffic against a transaction-level model ----
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        m_idle_from = 0; m_issue_cyc = -10; m_ack_cyc = -10;
        m_port = 1'b0; m_last = 1'b1; m_wr = 1'b0;
        m_addr = 8'h00; m_wdata = 8'h00; m_rd_exp = 8'h00; m_rdata = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            e_ack = (cyc == m_ack_cyc);
            if (e_ack && !m_wr) m_rdata = m_rd_exp;
            chk("rnd_ack0", ack0, e_ack && !m_port);
            chk("rnd_ack1", ack1, e_ack && m_port);
            chk("rnd_busy", busy, cyc < m_idle_from);
            chk("rnd_rdata", rdata, m_rdata);
            chk("rnd_gnt", gnt_id, m_port);
            chk("rnd_ce", mem_ce, cyc == m_issue_cyc);
            if (cyc == m_issue_cyc) begin
                chk("rnd_dir", {mem_wren, mem_rden}, {m_wr, !m_wr});
                chk("rnd_addr", mem_addr, m_addr);
                if (m_wr) chk("rnd_wdata", mem_wr_data, m_wdata);
            end
            for (int p = 0; p < 2; p++) begin
                if (e_ack && m_port == p[0]) begin
                    if ($urandom_range(0, 1) == 1) rnd_op(p[0], 1'b1);
                    else set_port(p[0], 1'b0, 1'b0, 8'h00, 8'h00);
                end else if (cyc < m_idle_from && m_port == p[0]) begin
                    rnd_op(p[0], p[0] ? req1 : req0);
                end else if (!(p[0] ? req1 : req0) && $urandom_range(0, 3) == 0) begin
                    rnd_op(p[0], 1'b1);
                end
            end
            if (cyc >= m_idle_from && (req0 || req1)) begin
                win         = (req0 && req1) ? !m_last : req1;
                m_port      = win;
                m_last      = win;
                m_wr        = win ? wr1 : wr0;
                m_addr      = win ? addr1 : addr0;
                m_wdata     = win ? wdata1 : wdata0;
                m_issue_cyc = cyc + 1;
                m_ack_cyc   = cyc + (m_wr ? 2 : 3);
                m_idle_from = m_ack_cyc + 1;
                if (m_wr) shadow[m_addr] = m_wdata;
                else      m_rd_exp = shadow[m_addr];
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
